adder_accum_display: RTL
========================

// Module: adder_accum_display
// PURPOSE
//  Parametrised successor of the 4-bit adder/seven-segment demo: WIDTH-bit adder with registered
//  result, accumulate mode and debounced press counter. Output is one time-multiplexed NDIG-digit
//  hex seven-segment display instead of one decoder per value.
//  Sits between board switches/push-button and the 7-seg bank; single clock domain.
// PARAMETERS
//  WIDTH       4     operand width (a, b); result is WIDTH+1 bits incl. carry
//  CNT_W       4     press-counter width
//  NDIG        3     display digits (>=2); digits 0..NDIG-2 show result, digit NDIG-1 shows count[3:0]
//  DEB_CYCLES  16    cycles raw button must be stable before the debounced level changes
//  SCAN_DIV    1024  clk cycles each digit stays enabled
// PORTS
//  clk      in   1        system clock, all logic on rising edge
//  reset    in   1        synchronous, active-low reset
//  a        in   WIDTH    operand A
//  b        in   WIDTH    operand B
//  cin      in   1        carry in
//  btn      in   1        raw asynchronous push-button, active-high
//  mode     in   1        0 = add (result<=a+b+cin), 1 = accumulate (acc<=acc+b+cin)
//  result   out  WIDTH+1  registered {carry, sum}
//  count    out  CNT_W    number of accepted presses, modulo 2^CNT_W
//  seg      out  7        active-low segments, seg[0]=a .. seg[6]=g, registered
//  an       out  NDIG     active-low one-hot digit enable, registered
// BEHAVIOUR
//  Reset (reset==0 at clk edge, overrides all else): result=0, acc=0, count=0, scan idx=0,
//   scan counter=0, debouncer IDLE, an=all 1s, seg=7'h7F.
//  Button path: 2-flop synchronizer -> debouncer FSM:
//   IDLE -(btn_s=1)-> PRESS_WAIT; PRESS_WAIT: counts while btn_s=1, reaching DEB_CYCLES-1 -> PRESSED
//   and emits 1-cycle press pulse; btn_s=0 -> IDLE, counter cleared.
//   PRESSED -(btn_s=0)-> RELEASE_WAIT; RELEASE_WAIT: DEB_CYCLES stable 0 -> IDLE; btn_s=1 -> PRESSED.
//   Exactly one pulse per debounced press; holding the button gives no repeats.
//  On press pulse (mode, a, b, cin sampled that cycle, result updates next edge):
//   mode 0: result <= a+b+cin (WIDTH+1 bits); acc <= a+b+cin truncated to WIDTH.
//   mode 1: {c,s} = acc+b+cin; acc <= s; result <= {c,s}; carry not sticky.
//   count <= count+1, wraps 2^CNT_W-1 -> 0.
//  No press: result, acc, count hold; a/b/cin changes have no effect.
//  Scan: counter 0..SCAN_DIV-1; at SCAN_DIV-1 idx advances, NDIG-1 wraps to 0.
//   Nibble i of result (zero-extended/truncated) on digit i<NDIG-1; count[3:0] (zero-ext) on top digit.
//   an/seg registered: reflect idx one cycle after it changes; never two digits enabled.
//  Hex decode 0-F full set (b=7'h03, d=7'h21 style lower-case for b,d).
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: result digits above most-significant non-zero result nibble
//   drive seg=7'h7F (an unchanged); digit 0 and count digit never blanked.
//  Undefined: all digits always show their nibble, leading zeros included.
// STRUCTURE
//  Package adder_disp_pkg: deb_state_t enum {IDLE,PRESS_WAIT,PRESSED,RELEASE_WAIT}, SEG_BLANK=7'h7F,
//   function hex_to_seg(logic [3:0]) -> logic [6:0] (active-low).
//  Sub-module btn_debounce #(DEB_CYCLES) (clk, reset, btn, press_pulse, level): sync + FSM.
//  Top: operand/accumulator regs, press counter, scan counter, mux, decode, output regs.
// TESTING
//  1 reset=0 for 2 cycles, any inputs -> an=3'b111, seg=7'h7F, result=0, count=0.
//  2 mode=0,a=9,b=8,cin=1, clean press DEB_CYCLES+5 cycles -> single pulse, result=5'h12,
//    count=1; when an=3'b110, seg=7'b0100100 ('2').
//  3 btn toggling every 3 cycles for 60 cycles (DEB_CYCLES=16) -> no pulse, count/result unchanged.
//  4 mode=1,b=7,cin=0, three presses -> result 5'h07, 5'h0E, 5'h15; 16 total presses -> count=0.
//  5 SCAN_DIV=4,NDIG=3 -> an cycles 110,101,011 each 4 cycles; count digit shows count; with
//    LEADING_ZERO_BLANK_EN and result=5'h03 digit1 seg=7'h7F, digit0 shows '3'.
//  6 reset=0 asserted in PRESS_WAIT and in PRESSED -> no pulse; after release button must be
//    released and re-pressed for next count.

Source files
------------

// File: rtl/adder_disp_pkg.sv
// Shared types and helpers for the adder / accumulator / display block.
//   deb_state_t : push-button debouncer states
//   SEG_BLANK   : active-low pattern with every segment dark
//   hex_to_seg  : 4-bit value -> active-low segments, seg[0]=a .. seg[6]=g
package adder_disp_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    // 'b' and 'd' use the lower-case shapes so they differ from '8' and '0'.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a debounce FSM.
// Ports:
//   clk, reset   : clock, synchronous active-low reset
//   btn          : raw asynchronous button, active-high
//   press_pulse  : one-cycle pulse per debounced press
//   level        : debounced button level
//   state        : current FSM state (debug observation)
// A press is accepted only after btn has been stable high for DEB_CYCLES
// cycles; the button must then be stable low for DEB_CYCLES cycles before a
// new press can start.
module btn_debounce
    import adder_disp_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    output logic       press_pulse,
    output logic       level,
    output deb_state_t state
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          btn_s;
    logic          armed;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    deb_state_t    state_n;

    assign btn_s = sync_q[1];

    // The synchronizer resets to "pressed" and 'armed' stays low until a
    // released button has been seen, so a button held through reset is not
    // counted: it has to be released and pressed again.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= 2'b11;
            armed  <= 1'b0;
            state  <= IDLE;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[0], btn};
            armed  <= armed | ~btn_s;
            state  <= state_n;
            cnt    <= cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        press_pulse = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (btn_s && armed) begin
                    state_n = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n     = PRESSED;
                    cnt_n       = '0;
                    press_pulse = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            PRESSED: begin
                cnt_n = '0;
                if (!btn_s) begin
                    state_n = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign level = (state == PRESSED) || (state == RELEASE_WAIT);

endmodule

// File: rtl/adder_accum_display.sv
// WIDTH-bit adder with registered result, accumulate mode, debounced press
// counter and a time-multiplexed NDIG-digit hex seven-segment display.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   a, b, cin  : operands and carry in (sampled on a debounced press)
//   btn        : raw push-button, active-high
//   mode       : 0 = result <= a+b+cin, 1 = acc <= acc+b+cin
//   result     : registered {carry, sum}
//   count      : accepted presses modulo 2^CNT_W
//   seg        : active-low segments {g..a}, registered
//   an         : active-low one-hot digit enable, registered
// Digits 0..NDIG-2 show result nibbles, digit NDIG-1 shows count[3:0].
// Build option LEADING_ZERO_BLANK_EN: result digits above the most
// significant non-zero result nibble are blanked (digit 0 and the count
// digit always show their value).
module adder_accum_display
    import adder_disp_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int CNT_W      = 4,
    parameter int NDIG       = 3,
    parameter int DEB_CYCLES = 16,
    parameter int SCAN_DIV   = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             btn,
    input  logic             mode,
    output logic [WIDTH:0]   result,
    output logic [CNT_W-1:0] count,
    output logic [6:0]       seg,
    output logic [NDIG-1:0]  an
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NDIG);
    // Wide enough that every displayed nibble index lands inside the vector.
    localparam int PW = 4 * NDIG + WIDTH + 1;

    logic             press_pulse;
    logic             btn_level;
    deb_state_t       deb_state;
    logic             dbg_unused;

    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   acc_sum;

    logic [SW-1:0]    scan_cnt;
    logic [IW-1:0]    idx;

    logic [PW-1:0]    res_pad;
    logic [CNT_W+3:0] cnt_pad;
    logic [3:0]       nib;
    logic             blank;
    logic [6:0]       seg_n;
    logic [NDIG-1:0]  an_n;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .press_pulse(press_pulse),
        .level      (btn_level),
        .state      (deb_state)
    );

    // Debounced level and FSM state are observation points only.
    assign dbg_unused = ^{btn_level, deb_state};

    assign add_sum = {1'b0, a}   + {1'b0, b} + (WIDTH+1)'(cin);
    assign acc_sum = {1'b0, acc} + {1'b0, b} + (WIDTH+1)'(cin);

    // Arithmetic state only moves on a debounced press.
    always_ff @(posedge clk) begin
        if (!reset) begin
            result <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (press_pulse) begin
            if (mode) begin
                result <= acc_sum;
                acc    <= acc_sum[WIDTH-1:0];
            end else begin
                result <= add_sum;
                acc    <= add_sum[WIDTH-1:0];
            end
            count <= count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    assign res_pad = PW'(result);
    assign cnt_pad = {4'b0000, count};

    always_comb begin
        nib   = 4'h0;
        blank = 1'b0;
        if (idx == IW'(NDIG - 1)) begin
            nib = cnt_pad[3:0];
        end else begin
            nib = res_pad[4*int'(idx) +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            // Blank when this nibble and every nibble above it is zero.
            blank = (idx != '0) && ((res_pad >> (4 * int'(idx))) == '0);
`else
            blank = 1'b0;
`endif
        end
        seg_n = blank ? SEG_BLANK : hex_to_seg(nib);
        an_n  = ~(NDIG'(1) << idx);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            an  <= '1;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_n;
            seg <= seg_n;
        end
    end

endmodule
